// File: rtl/fsk_ber_monitor.sv
// rtl/fsk_ber_monitor.sv - FSK symbol/bit error-rate monitor with tx reference FIFO (optional macro FSK_BER_BITERR_EN)
module fsk_ber_monitor #(
    parameter int SYM_W  = 4,
    parameter int DEPTH  = 32,
    parameter int CNT_W  = 32,
    parameter int SKIP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [SKIP_W-1:0] skip_cfg,
    input  logic [CNT_W-1:0]  num_sym,
    input  logic              tx_valid,
    input  logic [SYM_W-1:0]  tx_sym,
    input  logic              rx_valid,
    input  logic [SYM_W-1:0]  rx_sym,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  sym_err_cnt,
    output logic [CNT_W-1:0]  bit_err_cnt,
    output logic [CNT_W-1:0]  total_cnt,
    output logic              ovf,
    output logic              unf,
    output logic              sat
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CMAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_SKIP, S_MEASURE, S_DONE} state_t;

    state_t             state_q;
    logic               busy_q, done_q, ovf_q, unf_q, sat_q;
    logic [SKIP_W-1:0]  skip_q;
    logic [CNT_W-1:0]   num_q;
    logic [CNT_W-1:0]   sym_err_q, sym_err_d, total_q, total_d;
    logic [SYM_W-1:0]   mem_q [DEPTH];
    logic [AW:0]        wr_ptr_q, rd_ptr_q;

    logic               active, fifo_empty, fifo_full, push, pop, drop;
    logic               meas_hit, mismatch, meas_end, bit_sat;
    logic [SYM_W-1:0]   head, diff;

    // The extra pointer bit distinguishes full from empty when the indices match
    assign active     = (state_q == S_SKIP) || (state_q == S_MEASURE);
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head       = mem_q[rd_ptr_q[AW-1:0]];
    assign pop        = active && rx_valid && !fifo_empty;
    assign push       = active && tx_valid && (!fifo_full || pop);
    assign drop       = active && tx_valid && fifo_full && !pop;
    assign meas_hit   = (state_q == S_MEASURE) && rx_valid && !start;
    assign diff       = head ^ rx_sym;
    assign mismatch   = fifo_empty || (diff != '0);

    // Saturating next values for the symbol and total counters on a compare
    always_comb begin
        total_d   = (total_q == CMAX) ? CMAX : total_q + 1'b1;
        sym_err_d = sym_err_q;
        if (mismatch) begin
            sym_err_d = (sym_err_q == CMAX) ? CMAX : sym_err_q + 1'b1;
        end
        meas_end = (total_d == num_q) || (total_d == CMAX);
    end

`ifdef FSK_BER_BITERR_EN
    localparam int PC_W = $clog2(SYM_W + 1);
    logic [PC_W-1:0]  pc;
    logic [CNT_W-1:0] bit_inc, bit_err_q, bit_err_d;
    logic [CNT_W:0]   bit_sum;

    // Popcount of the differing bits; an empty FIFO charges a full symbol of bit errors
    always_comb begin
        pc = '0;
        for (int i = 0; i < SYM_W; i++) begin
            pc = pc + PC_W'(diff[i]);
        end
        bit_inc   = fifo_empty ? CNT_W'(SYM_W) : CNT_W'(pc);
        bit_sum   = {1'b0, bit_err_q} + {1'b0, bit_inc};
        bit_err_d = bit_sum[CNT_W] ? CMAX : bit_sum[CNT_W-1:0];
        bit_sat   = (bit_err_d == CMAX);
    end

    // Bit error accumulator, cleared by reset or a new measurement
    always_ff @(posedge clk) begin
        if (reset || start) begin
            bit_err_q <= '0;
        end else if (meas_hit) begin
            bit_err_q <= bit_err_d;
        end
    end

    assign bit_err_cnt = bit_err_q;
`else
    assign bit_err_cnt = '0;
    assign bit_sat     = 1'b0;
`endif

    // Reference FIFO storage; pointers live with the FSM so start can flush them
    always_ff @(posedge clk) begin
        if (push && !start) begin
            mem_q[wr_ptr_q[AW-1:0]] <= tx_sym;
        end
    end

    // Measurement FSM with FIFO pointers, counters and sticky flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            sat_q     <= 1'b0;
            skip_q    <= '0;
            num_q     <= '0;
            sym_err_q <= '0;
            total_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else if (start) begin
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            sat_q     <= 1'b0;
            sym_err_q <= '0;
            total_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            skip_q    <= skip_cfg;
            num_q     <= num_sym;
            if (num_sym == '0) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
            end else begin
                state_q <= (skip_cfg != '0) ? S_SKIP : S_MEASURE;
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
            end
        end else begin
            done_q <= 1'b0;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (drop) ovf_q <= 1'b1;
            case (state_q)
                S_SKIP: begin
                    if (rx_valid) begin
                        if (fifo_empty) unf_q <= 1'b1;
                        skip_q <= skip_q - 1'b1;
                        if (skip_q == SKIP_W'(1)) state_q <= S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    if (rx_valid) begin
                        if (fifo_empty) unf_q <= 1'b1;
                        total_q   <= total_d;
                        sym_err_q <= sym_err_d;
                        if ((total_d == CMAX) || (sym_err_d == CMAX) || bit_sat) sat_q <= 1'b1;
                        if (meas_end) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign sym_err_cnt = sym_err_q;
    assign total_cnt   = total_q;
    assign ovf         = ovf_q;
    assign unf         = unf_q;
    assign sat         = sat_q;
endmodule

// File: tb/tb_fsk_ber_monitor.sv
// tb/tb_fsk_ber_monitor.sv - directed self-checking bench for fsk_ber_monitor
module tb_fsk_ber_monitor;
`ifdef FSK_BER_BITERR_EN
    localparam bit BITERR = 1'b1;
`else
    localparam bit BITERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, tx_valid, rx_valid;
    logic [7:0]  skip_cfg;
    logic [31:0] num_sym;
    logic [3:0]  tx_sym, rx_sym;

    logic        a_busy, a_done, a_ovf, a_unf, a_sat;
    logic [31:0] a_sym, a_bit, a_tot;
    logic        b_busy, b_done, b_ovf, b_unf, b_sat;
    logic [31:0] b_sym, b_bit, b_tot;
    logic        c_busy, c_done, c_ovf, c_unf, c_sat;
    logic [3:0]  c_sym, c_bit, c_tot;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fsk_ber_monitor #(.SYM_W(4), .DEPTH(32), .CNT_W(32), .SKIP_W(8)) u_a (
        .clk(clk), .reset(reset), .start(start), .skip_cfg(skip_cfg), .num_sym(num_sym),
        .tx_valid(tx_valid), .tx_sym(tx_sym), .rx_valid(rx_valid), .rx_sym(rx_sym),
        .busy(a_busy), .done(a_done), .sym_err_cnt(a_sym), .bit_err_cnt(a_bit),
        .total_cnt(a_tot), .ovf(a_ovf), .unf(a_unf), .sat(a_sat));

    fsk_ber_monitor #(.SYM_W(1), .DEPTH(32), .CNT_W(32), .SKIP_W(8)) u_b (
        .clk(clk), .reset(reset), .start(start), .skip_cfg(skip_cfg), .num_sym(num_sym),
        .tx_valid(tx_valid), .tx_sym(tx_sym[0:0]), .rx_valid(rx_valid), .rx_sym(rx_sym[0:0]),
        .busy(b_busy), .done(b_done), .sym_err_cnt(b_sym), .bit_err_cnt(b_bit),
        .total_cnt(b_tot), .ovf(b_ovf), .unf(b_unf), .sat(b_sat));

    fsk_ber_monitor #(.SYM_W(2), .DEPTH(4), .CNT_W(4), .SKIP_W(8)) u_c (
        .clk(clk), .reset(reset), .start(start), .skip_cfg(skip_cfg), .num_sym(num_sym[3:0]),
        .tx_valid(tx_valid), .tx_sym(tx_sym[1:0]), .rx_valid(rx_valid), .rx_sym(rx_sym[1:0]),
        .busy(c_busy), .done(c_done), .sym_err_cnt(c_sym), .bit_err_cnt(c_bit),
        .total_cnt(c_tot), .ovf(c_ovf), .unf(c_unf), .sat(c_sat));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] sk, input logic [31:0] n);
        skip_cfg = sk;
        num_sym  = n;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    function automatic logic [3:0] pat(input int k);
        return 4'(k * 7 + 3);
    endfunction

    // tx sends n symbols; rx replays them dly cycles later, corrupting every
    // 'every'-th symbol and the first 'first_bad' symbols with mask
    task automatic run(input int n, input int dly, input int every, input int first_bad,
                       input logic [3:0] mask);
        for (int c = 0; c < n + dly; c++) begin
            int k;
            k        = c - dly;
            tx_valid = (c < n);
            tx_sym   = pat(c);
            rx_valid = (c >= dly);
            rx_sym   = pat(k);
            if (c >= dly && ((every != 0 && (k % every) == every - 1) || k < first_bad))
                rx_sym = rx_sym ^ mask;
            tick();
        end
        tx_valid = 1'b0;
        rx_valid = 1'b0;
    endtask

    initial begin
        bit seen_done;
        reset = 1'b1; start = 1'b0; tx_valid = 1'b0; rx_valid = 1'b0;
        skip_cfg = '0; num_sym = '0; tx_sym = '0; rx_sym = '0;
        tick(); tick();
        reset = 1'b0;

        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_tot", a_tot, 0);
        check("rst_flags", {a_ovf, a_unf, a_sat}, 0);

        // num_sym = 0: done one cycle after start, busy never rises
        do_start(8'd5, 32'd0);
        check("zero_done", a_done, 1);
        check("zero_busy", a_busy, 0);
        check("zero_tot", a_tot, 0);
        tick();
        check("zero_done_drop", a_done, 0);
        check("zero_busy2", a_busy, 0);

        // BFSK, rx delayed by 3, clean
        do_start(8'd0, 32'd100);
        check("b_busy_start", b_busy, 1);
        run(100, 3, 0, 0, 4'h0);
        check("b_done", b_done, 1);
        check("b_busy_end", b_busy, 0);
        check("b_tot", b_tot, 100);
        check("b_sym", b_sym, 0);
        check("b_bit", b_bit, 0);
        tick();
        check("b_done_pulse", b_done, 0);
        check("b_tot_hold", b_tot, 100);

        // 16-FSK, every 5th symbol XOR 0101
        do_start(8'd0, 32'd50);
        run(50, 2, 5, 0, 4'b0101);
        check("a_done", a_done, 1);
        check("a_tot", a_tot, 50);
        check("a_sym", a_sym, 10);
        check("a_bit", a_bit, BITERR ? 20 : 0);
        check("a_sat", a_sat, 0);
        check("a_unf", a_unf, 0);

        // skip two garbage symbols, then 10 clean; no idle cycle at phase change
        do_start(8'd2, 32'd10);
        run(12, 1, 0, 2, 4'hF);
        check("skip_done", a_done, 1);
        check("skip_sym", a_sym, 0);
        check("skip_tot", a_tot, 10);

        // DEPTH=4: six pushes, no rx -> overflow
        do_start(8'd0, 32'd10);
        tx_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tx_sym = pat(i);
            tick();
        end
        tx_valid = 1'b0;
        check("c_ovf", c_ovf, 1);
        check("a_no_ovf", a_ovf, 0);
        do_start(8'd0, 32'd10);
        check("c_ovf_clr", c_ovf, 0);
        rx_valid = 1'b1; rx_sym = 4'h0;
        tick();
        rx_valid = 1'b0;
        check("c_unf", c_unf, 1);
        check("c_unf_sym", c_sym, 1);
        check("c_unf_bit", c_bit, BITERR ? 2 : 0);
        check("c_unf_tot", c_tot, 1);

        // full FIFO with simultaneous push/pop loses nothing
        do_start(8'd0, 32'd8);
        run(8, 4, 0, 0, 4'h0);
        check("full_done", c_done, 1);
        check("full_ovf", c_ovf, 0);
        check("full_sym", c_sym, 0);
        check("full_tot", c_tot, 8);

        // CNT_W=4, SYM_W=2, all symbols wrong -> saturation
        do_start(8'd0, 32'd15);
        run(15, 1, 1, 0, 4'b0011);
        check("sat_done", c_done, 1);
        check("sat_flag", c_sat, 1);
        check("sat_sym", c_sym, 15);
        check("sat_bit", c_bit, BITERR ? 15 : 0);
        check("sat_tot", c_tot, 15);

        // restart mid-run, then reset mid-run
        do_start(8'd0, 32'd50);
        run(20, 1, 5, 0, 4'b0101);
        check("mid_sym", a_sym, 4);
        check("mid_bit", a_bit, BITERR ? 8 : 0);
        check("mid_busy", a_busy, 1);
        do_start(8'd0, 32'd50);
        check("restart_tot", a_tot, 0);
        check("restart_sym", a_sym, 0);
        check("restart_bit", a_bit, 0);
        check("restart_busy", a_busy, 1);
        run(10, 1, 0, 0, 4'h0);
        check("rerun_tot", a_tot, 10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_busy", a_busy, 0);
        check("rst_mid_tot", a_tot, 0);
        seen_done = a_done;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen_done = seen_done | a_done;
        end
        check("rst_mid_no_done", seen_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
